// File: rtl/rv32im_ctrl_pipe.sv
// ID-stage decoder that drives the ID/EX control register, with bubble and flush
// insertion, illegal-instruction flagging and a hold sequencer for multi-cycle MUL/DIV.
module rv32im_ctrl_pipe #(
    parameter int ALUOP_W     = 5,
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 4,
    parameter bit ENABLE_M    = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               INSTR_VALID,
    input  logic [31:0]        INSTRUCTION,
    input  logic               BUSY_WAIT,
    input  logic               FLUSH,
    output logic               STALL_OUT,
    output logic               MDU_START,
    output logic               CTRL_VALID,
    output logic               ILLEGAL,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [2:0]         IMM_SEL,
    output logic               OP1SEL,
    output logic               OP2SEL,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic               REG_WRITE_EN,
    output logic               WB_SEL,
    output logic               JAL_SEL,
    output logic [1:0]         BRANCH_JUMP,
    output logic [2:0]         FUNCT3,
    output logic [4:0]         RD,
    output logic [4:0]         RS1,
    output logic [4:0]         RS2
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;
    localparam logic [4:0] ALU_SLT    = 5'b10000;
    localparam logic [4:0] ALU_SLTU   = 5'b10001;
    localparam logic [4:0] ALU_PASSB  = 5'b10010;

    typedef struct packed {
        logic               vld;
        logic [ALUOP_W-1:0] aluop;
        logic [2:0]         imm_sel;
        logic               op1sel;
        logic               op2sel;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write_en;
        logic               wb_sel;
        logic               jal_sel;
        logic [1:0]         branch_jump;
        logic [2:0]         funct3;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
    } ctrl_t;

    typedef enum logic {IDLE, MWAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d, dec;
    logic             illegal_q, illegal_d;
    logic             start_q, start_d;
    logic             dec_ill, is_mul, is_div;
    logic [4:0]       alu;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opc = INSTRUCTION[6:0];
    assign f3  = INSTRUCTION[14:12];
    assign f7  = INSTRUCTION[31:25];

    always_comb begin
        dec         = '0;
        dec.vld     = 1'b1;
        dec.funct3  = f3;
        dec.rd      = INSTRUCTION[11:7];
        dec.rs1     = INSTRUCTION[19:15];
        dec.rs2     = INSTRUCTION[24:20];
        alu         = ALU_ADD;
        dec_ill     = 1'b0;
        is_mul      = 1'b0;
        is_div      = 1'b0;
        case (opc)
            OPC_LUI: begin
                alu              = ALU_PASSB;
                dec.imm_sel      = IMM_U;
                dec.reg_write_en = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm_sel      = IMM_U;
                dec.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                dec.imm_sel      = IMM_J;
                dec.reg_write_en = 1'b1;
                dec.jal_sel      = 1'b1;
                dec.branch_jump  = 2'b01;
            end
            OPC_JALR: begin
                dec_ill          = (f3 != 3'b000);
                dec.op1sel       = 1'b1;
                dec.imm_sel      = IMM_I;
                dec.reg_write_en = 1'b1;
                dec.jal_sel      = 1'b1;
                dec.branch_jump  = 2'b01;
            end
            OPC_BR: begin
                dec_ill         = (f3 == 3'b010) || (f3 == 3'b011);
                alu             = ALU_SUB;
                dec.imm_sel     = IMM_B;
                dec.op1sel      = 1'b1;
                dec.op2sel      = 1'b1;
                dec.branch_jump = 2'b10;
            end
            OPC_LD: begin
                dec_ill          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                dec.op1sel       = 1'b1;
                dec.imm_sel      = IMM_I;
                dec.mem_read     = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_sel       = 1'b1;
            end
            OPC_ST: begin
                dec_ill       = f3[2] || (f3 == 3'b011);
                dec.op1sel    = 1'b1;
                dec.imm_sel   = IMM_S;
                dec.mem_write = 1'b1;
            end
            OPC_IMM: begin
                dec.op1sel       = 1'b1;
                dec.imm_sel      = IMM_I;
                dec.reg_write_en = 1'b1;
                case (f3)
                    3'b000:  alu = ALU_ADD;
                    3'b010:  alu = ALU_SLT;
                    3'b011:  alu = ALU_SLTU;
                    3'b100:  alu = ALU_XOR;
                    3'b110:  alu = ALU_OR;
                    3'b111:  alu = ALU_AND;
                    3'b001: begin
                        alu     = ALU_SLL;
                        dec_ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        // shift-right immediates: funct7 distinguishes logical vs arithmetic
                        if (f7 == 7'b0000000)      alu = ALU_SRL;
                        else if (f7 == 7'b0100000) alu = ALU_SRA;
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec.op1sel       = 1'b1;
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  alu = ALU_ADD;
                        3'b001:  alu = ALU_SLL;
                        3'b010:  alu = ALU_SLT;
                        3'b011:  alu = ALU_SLTU;
                        3'b100:  alu = ALU_XOR;
                        3'b101:  alu = ALU_SRL;
                        3'b110:  alu = ALU_OR;
                        default: alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      alu = ALU_SUB;
                    else if (f3 == 3'b101) alu = ALU_SRA;
                    else                   dec_ill = 1'b1;
                end else if (f7 == 7'b0000001 && ENABLE_M) begin
                    is_mul = ~f3[2];
                    is_div = f3[2];
                    case (f3)
                        3'b000:  alu = ALU_MUL;
                        3'b001:  alu = ALU_MULH;
                        3'b010:  alu = ALU_MULHSU;
                        3'b011:  alu = ALU_MULHU;
                        3'b100:  alu = ALU_DIV;
                        3'b101:  alu = ALU_DIVU;
                        3'b110:  alu = ALU_REM;
                        default: alu = ALU_REMU;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        dec.aluop = ALUOP_W'(alu);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = 1'b0;
        start_d   = 1'b0;
        if (FLUSH) begin
            ctrl_d  = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == MWAIT) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!INSTR_VALID || dec_ill) begin
            ctrl_d    = '0;
            illegal_d = INSTR_VALID;
        end else begin
            ctrl_d = dec;
            if (is_mul && MUL_LATENCY > 1) begin
                state_d = MWAIT;
                cnt_d   = CNT_W'(MUL_LATENCY - 1);
                start_d = 1'b1;
            end else if (is_div && DIV_LATENCY > 1) begin
                state_d = MWAIT;
                cnt_d   = CNT_W'(DIV_LATENCY - 1);
                start_d = 1'b1;
            end
        end
    end

    // A memory stall freezes everything, including a pending start pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
        end else if (!BUSY_WAIT) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            start_q   <= start_d;
        end
    end

    assign STALL_OUT    = (state_q == MWAIT);
    assign MDU_START    = start_q & ~BUSY_WAIT;
    assign ILLEGAL      = illegal_q;
    assign CTRL_VALID   = ctrl_q.vld;
    assign ALUOP        = ctrl_q.aluop;
    assign IMM_SEL      = ctrl_q.imm_sel;
    assign OP1SEL       = ctrl_q.op1sel;
    assign OP2SEL       = ctrl_q.op2sel;
    assign MEM_READ     = ctrl_q.mem_read;
    assign MEM_WRITE    = ctrl_q.mem_write;
    assign REG_WRITE_EN = ctrl_q.reg_write_en;
    assign WB_SEL       = ctrl_q.wb_sel;
    assign JAL_SEL      = ctrl_q.jal_sel;
    assign BRANCH_JUMP  = ctrl_q.branch_jump;
    assign FUNCT3       = ctrl_q.funct3;
    assign RD           = ctrl_q.rd;
    assign RS1          = ctrl_q.rs1;
    assign RS2          = ctrl_q.rs2;

endmodule

// File: tb/tb_rv32im_ctrl_pipe.sv
// Directed bench for rv32im_ctrl_pipe: a default-configured instance plus an
// ENABLE_M=0 instance sharing the same stimulus.
module tb_rv32im_ctrl_pipe;

    logic        CLK;
    logic        RESET;
    logic        INSTR_VALID;
    logic [31:0] INSTRUCTION;
    logic        BUSY_WAIT;
    logic        FLUSH;

    logic       STALL_OUT, MDU_START, CTRL_VALID, ILLEGAL;
    logic [4:0] ALUOP;
    logic [2:0] IMM_SEL;
    logic       OP1SEL, OP2SEL, MEM_READ, MEM_WRITE, REG_WRITE_EN, WB_SEL, JAL_SEL;
    logic [1:0] BRANCH_JUMP;
    logic [2:0] FUNCT3;
    logic [4:0] RD, RS1, RS2;

    logic       n_stall, n_start, n_valid, n_illegal;
    logic [4:0] n_aluop;
    logic [2:0] n_imm_sel;
    logic       n_op1, n_op2, n_mrd, n_mwr, n_rwe, n_wb, n_jal;
    logic [1:0] n_bj;
    logic [2:0] n_f3;
    logic [4:0] n_rd, n_rs1, n_rs2;

    int total = 0;
    int bad   = 0;

    rv32im_ctrl_pipe #(.ALUOP_W(5), .MUL_LATENCY(1), .DIV_LATENCY(4), .ENABLE_M(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .BUSY_WAIT(BUSY_WAIT), .FLUSH(FLUSH), .STALL_OUT(STALL_OUT), .MDU_START(MDU_START),
        .CTRL_VALID(CTRL_VALID), .ILLEGAL(ILLEGAL), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
        .OP1SEL(OP1SEL), .OP2SEL(OP2SEL), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .REG_WRITE_EN(REG_WRITE_EN), .WB_SEL(WB_SEL), .JAL_SEL(JAL_SEL),
        .BRANCH_JUMP(BRANCH_JUMP), .FUNCT3(FUNCT3), .RD(RD), .RS1(RS1), .RS2(RS2)
    );

    rv32im_ctrl_pipe #(.ALUOP_W(5), .MUL_LATENCY(1), .DIV_LATENCY(4), .ENABLE_M(1'b0)) dut_nom (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .BUSY_WAIT(BUSY_WAIT), .FLUSH(FLUSH), .STALL_OUT(n_stall), .MDU_START(n_start),
        .CTRL_VALID(n_valid), .ILLEGAL(n_illegal), .ALUOP(n_aluop), .IMM_SEL(n_imm_sel),
        .OP1SEL(n_op1), .OP2SEL(n_op2), .MEM_READ(n_mrd), .MEM_WRITE(n_mwr),
        .REG_WRITE_EN(n_rwe), .WB_SEL(n_wb), .JAL_SEL(n_jal),
        .BRANCH_JUMP(n_bj), .FUNCT3(n_f3), .RD(n_rd), .RS1(n_rs1), .RS2(n_rs2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET       = 1'b1;
        INSTR_VALID = 1'b0;
        INSTRUCTION = 32'h0;
        BUSY_WAIT   = 1'b0;
        FLUSH       = 1'b0;
        step();
        step();
        chk("rst_valid", CTRL_VALID, 1'b0);
        chk("rst_stall", STALL_OUT, 1'b0);
        chk("rst_illegal", ILLEGAL, 1'b0);
        chk("rst_start", MDU_START, 1'b0);
        chk("rst_rwe", REG_WRITE_EN, 1'b0);
        chk("rst_aluop", ALUOP, 5'b00000);

        // ADD x3,x1,x2
        RESET = 1'b0; INSTR_VALID = 1'b1; INSTRUCTION = 32'h002081B3;
        step();
        chk("add_valid", CTRL_VALID, 1'b1);
        chk("add_aluop", ALUOP, 5'b00000);
        chk("add_rd", RD, 5'd3);
        chk("add_rs1", RS1, 5'd1);
        chk("add_rs2", RS2, 5'd2);
        chk("add_rwe", REG_WRITE_EN, 1'b1);
        chk("add_op1", OP1SEL, 1'b1);
        chk("add_op2", OP2SEL, 1'b1);
        chk("add_stall", STALL_OUT, 1'b0);
        chk("nom_add_valid", n_valid, 1'b1);

        // SUB then SRAI back-to-back
        INSTRUCTION = 32'h402081B3;
        step();
        chk("sub_aluop", ALUOP, 5'b00001);
        INSTRUCTION = 32'h4030D093;
        step();
        chk("srai_aluop", ALUOP, 5'b00111);
        chk("srai_imm", IMM_SEL, 3'b000);
        chk("srai_op2", OP2SEL, 1'b0);
        chk("srai_rd", RD, 5'd1);
        chk("srai_f3", FUNCT3, 3'b101);

        // BEQ x1,x2,8
        INSTRUCTION = 32'h00208463;
        step();
        chk("beq_bj", BRANCH_JUMP, 2'b10);
        chk("beq_aluop", ALUOP, 5'b00001);
        chk("beq_imm", IMM_SEL, 3'b010);
        chk("beq_rwe", REG_WRITE_EN, 1'b0);

        // JAL x1,8
        INSTRUCTION = 32'h008000EF;
        step();
        chk("jal_bj", BRANCH_JUMP, 2'b01);
        chk("jal_sel", JAL_SEL, 1'b1);
        chk("jal_imm", IMM_SEL, 3'b100);
        chk("jal_op1", OP1SEL, 1'b0);
        chk("jal_rwe", REG_WRITE_EN, 1'b1);

        // SW x2,4(x1)
        INSTRUCTION = 32'h0020A223;
        step();
        chk("sw_mwr", MEM_WRITE, 1'b1);
        chk("sw_imm", IMM_SEL, 3'b001);
        chk("sw_rwe", REG_WRITE_EN, 1'b0);

        // LUI x5,0x12345
        INSTRUCTION = 32'h123452B7;
        step();
        chk("lui_aluop", ALUOP, 5'b10010);
        chk("lui_imm", IMM_SEL, 3'b011);

        // MUL x5,x6,x7 with single-cycle latency: no hold, no start pulse
        INSTRUCTION = 32'h027302B3;
        step();
        chk("mul_aluop", ALUOP, 5'b01000);
        chk("mul_stall", STALL_OUT, 1'b0);
        chk("mul_start", MDU_START, 1'b0);

        // DIV x5,x6,x7: 3 stall cycles, ADD waiting in IF/ID
        INSTRUCTION = 32'h027342B3;
        step();
        chk("div_valid", CTRL_VALID, 1'b1);
        chk("div_aluop", ALUOP, 5'b01100);
        chk("div_start", MDU_START, 1'b1);
        chk("div_stall0", STALL_OUT, 1'b1);
        INSTRUCTION = 32'h002081B3;
        step();
        chk("div_start_off", MDU_START, 1'b0);
        chk("div_stall1", STALL_OUT, 1'b1);
        chk("div_hold1", ALUOP, 5'b01100);
        step();
        chk("div_stall2", STALL_OUT, 1'b1);
        step();
        chk("div_stall3", STALL_OUT, 1'b0);
        chk("div_hold3", ALUOP, 5'b01100);
        step();
        chk("div_next_aluop", ALUOP, 5'b00000);
        chk("div_next_rd", RD, 5'd3);

        // DIV with BUSY_WAIT for 2 cycles mid-hold: 5 stall cycles
        INSTRUCTION = 32'h027342B3;
        step();
        chk("dbw_stall0", STALL_OUT, 1'b1);
        chk("dbw_start", MDU_START, 1'b1);
        INSTRUCTION = 32'h002081B3;
        step();
        chk("dbw_stall1", STALL_OUT, 1'b1);
        BUSY_WAIT = 1'b1;
        step();
        chk("dbw_stall2", STALL_OUT, 1'b1);
        chk("dbw_hold2", ALUOP, 5'b01100);
        chk("dbw_rd2", RD, 5'd5);
        chk("dbw_start2", MDU_START, 1'b0);
        step();
        chk("dbw_stall3", STALL_OUT, 1'b1);
        chk("dbw_valid3", CTRL_VALID, 1'b1);
        BUSY_WAIT = 1'b0;
        step();
        chk("dbw_stall4", STALL_OUT, 1'b1);
        chk("dbw_hold4", ALUOP, 5'b01100);
        step();
        chk("dbw_stall5", STALL_OUT, 1'b0);
        chk("dbw_hold5", ALUOP, 5'b01100);
        step();
        chk("dbw_next", ALUOP, 5'b00000);

        // DIV aborted by FLUSH, then LW x1,8(x2)
        INSTRUCTION = 32'h027342B3;
        step();
        chk("dfl_stall0", STALL_OUT, 1'b1);
        step();
        FLUSH = 1'b1;
        step();
        chk("dfl_valid", CTRL_VALID, 1'b0);
        chk("dfl_rwe", REG_WRITE_EN, 1'b0);
        chk("dfl_stall", STALL_OUT, 1'b0);
        chk("dfl_aluop", ALUOP, 5'b00000);
        FLUSH = 1'b0;
        INSTRUCTION = 32'h00812083;
        step();
        chk("lw_mrd", MEM_READ, 1'b1);
        chk("lw_wb", WB_SEL, 1'b1);
        chk("lw_aluop", ALUOP, 5'b00000);
        chk("lw_rd", RD, 5'd1);
        chk("lw_valid", CTRL_VALID, 1'b1);

        // unknown opcode
        INSTRUCTION = 32'hFFFFFFFF;
        step();
        chk("ill_flag", ILLEGAL, 1'b1);
        chk("ill_valid", CTRL_VALID, 1'b0);
        chk("ill_rwe", REG_WRITE_EN, 1'b0);
        chk("ill_mrd", MEM_READ, 1'b0);
        chk("ill_mwr", MEM_WRITE, 1'b0);
        INSTR_VALID = 1'b0;
        step();
        chk("ill_pulse", ILLEGAL, 1'b0);
        chk("bubble_valid", CTRL_VALID, 1'b0);

        // bad funct7 on R-type
        INSTR_VALID = 1'b1; INSTRUCTION = 32'h202081B3;
        step();
        chk("f7_ill", ILLEGAL, 1'b1);
        chk("f7_valid", CTRL_VALID, 1'b0);

        // DIV on the instance without the M extension
        INSTRUCTION = 32'h027342B3;
        step();
        chk("nom_ill", n_illegal, 1'b1);
        chk("nom_valid", n_valid, 1'b0);
        chk("nom_rwe", n_rwe, 1'b0);
        chk("nom_stall", n_stall, 1'b0);
        INSTR_VALID = 1'b0;
        step();
        chk("nom_ill_pulse", n_illegal, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
